// File: rtl/light_pkg.sv
// Shared types and constants for the light sequencer: FSM states, step encodings,
// field widths and small step-ordering helpers.
package light_pkg;

  localparam int PERIOD_W = 8;
  localparam int CYC_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    STEP_S1 = 2'd0,
    STEP_S2 = 2'd1,
    STEP_S3 = 2'd2
  } step_t;

  localparam logic [2:0] LAMPS_OFF = 3'b000;

  // Lamp pattern {A,B,C} shown while a step is active.
  function automatic logic [2:0] step_lamps(input step_t s);
    logic [2:0] l;
    case (s)
      STEP_S1: l = 3'b100;
      STEP_S2: l = 3'b110;
      STEP_S3: l = 3'b111;
      default: l = LAMPS_OFF;
    endcase
    return l;
  endfunction

  function automatic step_t step_advance(input step_t s, input logic rev);
    step_t n;
    case (s)
      STEP_S1: n = rev ? STEP_S3 : STEP_S2;
      STEP_S2: n = rev ? STEP_S1 : STEP_S3;
      STEP_S3: n = rev ? STEP_S2 : STEP_S1;
      default: n = STEP_S1;
    endcase
    return n;
  endfunction

  // The step whose expiry closes one full sequence.
  function automatic logic is_last_step(input step_t s, input logic rev);
    return rev ? (s == STEP_S1) : (s == STEP_S3);
  endfunction

endpackage

// File: rtl/light_ctrl_if.sv
// Control/status bundle of the light sequencer. The dir field exists only when
// LIGHT_CTRL_REVERSE_EN is defined.
interface light_ctrl_if;
  import light_pkg::*;

  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] period;
  logic [CYC_W-1:0]    cycles;
`ifdef LIGHT_CTRL_REVERSE_EN
  logic                dir;
`endif
  logic                A;
  logic                B;
  logic                C;
  logic                busy;
  logic                done;

`ifdef LIGHT_CTRL_REVERSE_EN
  modport master (output start, stop, period, cycles, dir, input A, B, C, busy, done);
  modport slave  (input start, stop, period, cycles, dir, output A, B, C, busy, done);
`else
  modport master (output start, stop, period, cycles, input A, B, C, busy, done);
  modport slave  (input start, stop, period, cycles, output A, B, C, busy, done);
`endif

endinterface

// File: rtl/light_prescaler.sv
// Step dwell counter: load captures the reload value, then counts down while enabled
// and raises tick for the one clock in which the count sits at zero.
module light_prescaler
  import light_pkg::*;
#(
  parameter int W = PERIOD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tick
);

  logic [W-1:0] reload_reg;
  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_reg <= '0;
      cnt_reg    <= '0;
    end else if (load) begin
      reload_reg <= load_val;
      cnt_reg    <= load_val;
    end else if (en) begin
      if (cnt_reg == '0) begin
        cnt_reg <= reload_reg;
      end else begin
        cnt_reg <= cnt_reg - W'(1);
      end
    end
  end

  assign tick = en && (cnt_reg == '0);

endmodule

// File: rtl/light_ctrl.sv
// Three-lamp sequencer: IDLE/RUN FSM stepping S1->S2->S3 with a programmable dwell
// and sequence count. Define LIGHT_CTRL_REVERSE_EN to add the dir (reverse order) input.
module light_ctrl
  import light_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  light_ctrl_if.slave bus
);

  state_t           state_reg, state_next;
  step_t            step_reg, step_next;
  logic [CYC_W-1:0] seq_reg, seq_next, seq_inc;
  logic [CYC_W-1:0] cycles_reg, cycles_next;
  logic             rev_reg, rev_next;
  logic [2:0]       lamps_reg, lamps_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             pre_load;
  logic             tick;
  logic             dir_in;

`ifdef LIGHT_CTRL_REVERSE_EN
  assign dir_in = bus.dir;
`else
  assign dir_in = 1'b0;
`endif

  light_prescaler #(.W(PERIOD_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pre_load),
    .load_val (bus.period),
    .en       (state_reg == ST_RUN),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      step_reg   <= STEP_S1;
      seq_reg    <= '0;
      cycles_reg <= '0;
      rev_reg    <= 1'b0;
      lamps_reg  <= LAMPS_OFF;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      seq_reg    <= seq_next;
      cycles_reg <= cycles_next;
      rev_reg    <= rev_next;
      lamps_reg  <= lamps_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    seq_next    = seq_reg;
    cycles_next = cycles_reg;
    rev_next    = rev_reg;
    done_next   = 1'b0;
    pre_load    = 1'b0;
    seq_inc     = seq_reg + CYC_W'(1);

    case (state_reg)
      ST_IDLE: begin
        // stop has priority over start
        if (bus.start && !bus.stop) begin
          state_next  = ST_RUN;
          rev_next    = dir_in;
          step_next   = dir_in ? STEP_S3 : STEP_S1;
          seq_next    = '0;
          cycles_next = bus.cycles;
          pre_load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
          step_next  = STEP_S1;
          seq_next   = '0;
        end else if (tick) begin
          step_next = step_advance(step_reg, rev_reg);
          if (is_last_step(step_reg, rev_reg)) begin
            // cycles==0 lets the counter wrap freely and never completes
            seq_next = seq_inc;
            if ((cycles_reg != '0) && (seq_inc == cycles_reg)) begin
              state_next = ST_IDLE;
              step_next  = STEP_S1;
              seq_next   = '0;
              done_next  = 1'b1;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next  = (state_next == ST_RUN);
    lamps_next = busy_next ? step_lamps(step_next) : LAMPS_OFF;
  end

  assign bus.A    = lamps_reg[2];
  assign bus.B    = lamps_reg[1];
  assign bus.C    = lamps_reg[0];
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_light_ctrl.sv
// Scoreboard bench for light_ctrl: stimulus queues the expected lamps/busy/done
// after each edge; a monitor pops and compares on the falling edge (or on demand).
module tb_light_ctrl;
  import light_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  light_ctrl_if bus();

  light_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] abc;
    logic       busy;
    logic       done;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  task automatic push(input logic [2:0] abc, input logic bz, input logic dn, input string nm);
    exp_t e;
    e.abc  = abc;
    e.busy = bz;
    e.done = dn;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // Drive start/stop for the next edge, then queue the outputs expected after it.
  task automatic cyc(input logic st, input logic sp, input logic [2:0] abc,
                     input logic bz, input logic dn, input string nm);
    bus.start = st;
    bus.stop  = sp;
    @(posedge clk);
    #1;
    push(abc, bz, dn, nm);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic hold(input logic [2:0] abc, input logic bz, input int n, input string nm);
    repeat (n) cyc(1'b0, 1'b0, abc, bz, 1'b0, nm);
  endtask

  // Monitor
  initial begin : monitor
    exp_t       e;
    logic [2:0] act;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.A, bus.B, bus.C};
        checks++;
        if (act !== e.abc || bus.busy !== e.busy || bus.done !== e.done) begin
          errors++;
          $display("FAIL %s: got ABC=%b busy=%b done=%b, expected ABC=%b busy=%b done=%b",
                   e.nm, act, bus.busy, bus.done, e.abc, e.busy, e.done);
        end else begin
          $display("ok   %s: ABC=%b busy=%b done=%b", e.nm, act, bus.busy, bus.done);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.period = 8'd0;
    bus.cycles = 4'd0;
`ifdef LIGHT_CTRL_REVERSE_EN
    bus.dir    = 1'b0;
`endif

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    push(3'b000, 1'b0, 1'b0, "reset");
    @(posedge clk); #1;
    push(3'b000, 1'b0, 1'b0, "reset_hold");
    rst_n = 1'b1;

    // period=0, cycles=1, accepted on the first edge after reset release
    bus.period = 8'd0; bus.cycles = 4'd1;
    cyc(1, 0, 3'b100, 1, 0, "p0_s1");
    cyc(0, 0, 3'b110, 1, 0, "p0_s2");
    cyc(0, 0, 3'b111, 1, 0, "p0_s3");
    cyc(0, 0, 3'b000, 0, 1, "p0_done");
    cyc(0, 0, 3'b000, 0, 0, "p0_done_pulse_end");

    // period=3, cycles=2: each pattern held 4 clks, done at clk25
    bus.period = 8'd3; bus.cycles = 4'd2;
    cyc(1, 0, 3'b100, 1, 0, "p3_s1");
    hold(3'b100, 1, 3, "p3_s1");
    hold(3'b110, 1, 4, "p3_s2");
    hold(3'b111, 1, 4, "p3_s3");
    hold(3'b100, 1, 4, "p3_s1b");
    hold(3'b110, 1, 4, "p3_s2b");
    hold(3'b111, 1, 4, "p3_s3b");
    cyc(0, 0, 3'b000, 0, 1, "p3_done");

    // start in the done clock is accepted
    bus.period = 8'd0; bus.cycles = 4'd1;
    cyc(1, 0, 3'b100, 1, 0, "restart_on_done");
    cyc(0, 0, 3'b110, 1, 0, "restart_s2");
    cyc(0, 0, 3'b111, 1, 0, "restart_s3");
    cyc(0, 0, 3'b000, 0, 1, "restart_done");

    // cycles=0, period=1: repeats every 6 clks past the 15->0 wrap, then stop
    bus.period = 8'd1; bus.cycles = 4'd0;
    cyc(1, 0, 3'b100, 1, 0, "free_s1");
    hold(3'b100, 1, 1, "free_s1");
    for (int r = 0; r < 17; r++) begin
      hold(3'b110, 1, 2, "free_s2");
      hold(3'b111, 1, 2, "free_s3");
      hold(3'b100, 1, 2, "free_s1");
    end
    cyc(0, 1, 3'b000, 0, 0, "free_stop");
    cyc(0, 0, 3'b000, 0, 0, "free_stop_idle");

    // start and stop together in IDLE: stays IDLE
    cyc(1, 1, 3'b000, 0, 0, "start_stop_idle");
    cyc(0, 0, 3'b000, 0, 0, "still_idle");

    // period/cycles change and start pulse during RUN are ignored
    bus.period = 8'd2; bus.cycles = 4'd1;
    cyc(1, 0, 3'b100, 1, 0, "ign_s1");
    cyc(0, 0, 3'b100, 1, 0, "ign_s1");
    bus.period = 8'd9; bus.cycles = 4'd5;
    cyc(0, 0, 3'b100, 1, 0, "ign_s1");
    cyc(0, 0, 3'b110, 1, 0, "ign_s2");
    cyc(1, 0, 3'b110, 1, 0, "ign_start_pulse");
    cyc(0, 0, 3'b110, 1, 0, "ign_s2");
    hold(3'b111, 1, 3, "ign_s3");
    cyc(0, 0, 3'b000, 0, 1, "ign_done");

    // Asynchronous reset mid-S2, between edges
    bus.period = 8'd1; bus.cycles = 4'd0;
    cyc(1, 0, 3'b100, 1, 0, "ar_s1");
    cyc(0, 0, 3'b100, 1, 0, "ar_s1");
    cyc(0, 0, 3'b110, 1, 0, "ar_s2");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    push(3'b000, 1'b0, 1'b0, "async_reset_immediate");
    ->chk_ev;
    @(posedge clk); #1;
    push(3'b000, 1'b0, 1'b0, "async_reset_held");
    rst_n = 1'b1;
    cyc(1, 0, 3'b100, 1, 0, "post_reset_s1");
    cyc(0, 0, 3'b100, 1, 0, "post_reset_s1");
    cyc(0, 0, 3'b110, 1, 0, "post_reset_s2");
    cyc(0, 1, 3'b000, 0, 0, "post_reset_stop");

`ifdef LIGHT_CTRL_REVERSE_EN
    // Reverse order: S3->S2->S1, completion at S1 expiry
    bus.period = 8'd0; bus.cycles = 4'd1; bus.dir = 1'b1;
    cyc(1, 0, 3'b111, 1, 0, "rev_s3");
    bus.dir = 1'b0;
    cyc(0, 0, 3'b110, 1, 0, "rev_s2");
    cyc(0, 0, 3'b100, 1, 0, "rev_s1");
    cyc(0, 0, 3'b000, 0, 1, "rev_done");
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
